// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic [XLEN-1:0] neg_val(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? neg_val(v) : v;
  endfunction

endpackage

// File: rtl/muldiv_seq_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step
  import muldiv_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem_i < dvs_i always holds, so the shifted value fits in XLEN+1 bits
  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_i};
  assign rem_o   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_o   = {quo_i[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle multiply/divide sequencer with valid/ready in and out, one op in flight.
// Optional macro DIV_EARLY_OUT_EN: divides with |dividend| < |divisor| complete without iterating.
//
// state  | meaning
// S_IDLE | ready for a new request
// S_MUL  | registering the 64-bit product
// S_DIV  | restoring divide, one quotient bit per cycle (cnt 0..31)
// S_DONE | result valid, waiting for out_ready
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opr_1,
  input  logic [XLEN-1:0] opr_2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [XLEN-1:0]   rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              div_signed, div_zero, div_ovf, early, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;

  assign accept     = in_valid & in_ready;
  assign div_signed = ~op[0];
  assign a_mag      = abs_val(opr_1, div_signed);
  assign b_mag      = abs_val(opr_2, div_signed);
  assign div_zero   = (opr_2 == '0);
  assign div_ovf    = div_signed && (opr_1 == INT_MIN) && (opr_2 == '1);
`ifdef DIV_EARLY_OUT_EN
  assign early      = (a_mag < b_mag);
`else
  assign early      = 1'b0;
`endif
  assign special    = op[2] & (div_zero | div_ovf | early);

  // op[1] selects remainder; the early-out case shares the remainder = dividend answer
  always_comb begin
    special_res = '0;
    if (div_zero)     special_res = op[1] ? opr_1 : '1;
    else if (div_ovf) special_res = op[1] ? '0 : INT_MIN;
    else              special_res = op[1] ? opr_1 : '0;
  end

  // multiplier
  logic              s_a, s_b;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic [XLEN-1:0]   mul_res;

  assign s_a     = (op_q != OP_MULHU);
  assign s_b     = (op_q == OP_MULH);
  assign a_ext   = {{XLEN{s_a & a_q[XLEN-1]}}, a_q};
  assign b_ext   = {{XLEN{s_b & b_q[XLEN-1]}}, b_q};
  assign prod    = a_ext * b_ext;
  assign mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // divider iteration and sign fix-up
  logic [XLEN-1:0] rem_nxt, quo_nxt, div_res;
  logic            q_neg, r_neg;

  div_step u_div_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_nxt),
    .quo_o (quo_nxt)
  );

  assign q_neg   = ~op_q[0] & (a_q[XLEN-1] ^ b_q[XLEN-1]);
  assign r_neg   = ~op_q[0] & a_q[XLEN-1];
  assign div_res = op_q[1] ? (r_neg ? neg_val(rem_nxt) : rem_nxt)
                           : (q_neg ? neg_val(quo_nxt) : quo_nxt);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) state_d = !op[2] ? S_MUL : (special ? S_DONE : S_DIV);
        S_MUL:  state_d = S_DONE;
        S_DIV:  if (cnt_q == CNT_W'(XLEN-1)) state_d = S_DONE;
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE) & ~flush;
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  assign result = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q  <= op;
      a_q   <= opr_1;
      b_q   <= opr_2;
      rem_q <= '0;
      quo_q <= a_mag;
      dvs_q <= b_mag;
      cnt_q <= '0;
      if (special) result_q <= special_res;
    end else if (!flush) begin
      case (state_q)
        S_MUL: result_q <= mul_res;
        S_DIV: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) result_q <= div_res;
        end
        default: ;
      endcase
    end
  end

endmodule
